// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared width, bus-source select encoding and ALU op enum for datapath
package datapath_pkg;

    localparam int DATA_W = 32;

    // Bus sources, listed from highest to lowest drive priority
    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_PC   = 3'd1,
        BUS_ZHI  = 3'd2,
        BUS_ZLO  = 3'd3,
        BUS_MDR  = 3'd4,
        BUS_R2   = 3'd5,
        BUS_R3   = 3'd6
    } bus_sel_e;

    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_AND  = 2'd1,
        ALU_ADD  = 2'd2
    } alu_op_e;

endpackage

// File: rtl/datapath_reg32.sv
// rtl/datapath_reg32.sv - DATA_W register with synchronous active-high clear and load enable
module reg32
    import datapath_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         i_clk,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_clear)
            r_q <= '0;
        else if (i_load)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - single-bus CPU datapath slice; DATAPATH_ADD_EN makes AND=0 an adder instead of pass-through
module datapath
    import datapath_pkg::*;
(
    input  logic              Clock,
    input  logic              Clear,
    input  logic              PCout,
    input  logic              Zhighout,
    input  logic              Zlowout,
    input  logic              MDRout,
    input  logic              R2out,
    input  logic              R3out,
    input  logic              MARin,
    input  logic              Zin,
    input  logic              PCin,
    input  logic              MDRin,
    input  logic              IRin,
    input  logic              Yin,
    input  logic              IncPC,
    input  logic              Read,
    input  logic              AND,
    input  logic              R1in,
    input  logic              R2in,
    input  logic              R3in,
    input  logic [DATA_W-1:0] Mdatain
);

    // Register names are kept plain so they can be probed hierarchically
    logic [DATA_W-1:0] PC, IR, MAR, MDR, Y, Zhigh, Zlow, R1, R2, R3;

    bus_sel_e            w_bus_sel;
    alu_op_e             w_alu_op;
    logic [DATA_W-1:0]   w_bus;
    logic [DATA_W-1:0]   w_pc_d;
    logic [DATA_W-1:0]   w_mdr_d;
    logic [2*DATA_W-1:0] w_alu;

    always_comb begin
        w_bus_sel = BUS_NONE;
        if (PCout)         w_bus_sel = BUS_PC;
        else if (Zhighout) w_bus_sel = BUS_ZHI;
        else if (Zlowout)  w_bus_sel = BUS_ZLO;
        else if (MDRout)   w_bus_sel = BUS_MDR;
        else if (R2out)    w_bus_sel = BUS_R2;
        else if (R3out)    w_bus_sel = BUS_R3;
    end

    always_comb begin
        w_bus = '0;
        case (w_bus_sel)
            BUS_PC:  w_bus = PC;
            BUS_ZHI: w_bus = Zhigh;
            BUS_ZLO: w_bus = Zlow;
            BUS_MDR: w_bus = MDR;
            BUS_R2:  w_bus = R2;
            BUS_R3:  w_bus = R3;
            default: w_bus = '0;
        endcase
    end

    assign w_pc_d  = IncPC ? PC + 1'b1 : w_bus;
    assign w_mdr_d = Read ? Mdatain : w_bus;

`ifdef DATAPATH_ADD_EN
    assign w_alu_op = AND ? ALU_AND : ALU_ADD;
`else
    assign w_alu_op = AND ? ALU_AND : ALU_PASS;
`endif

    always_comb begin
        w_alu = '0;
        case (w_alu_op)
            ALU_AND: w_alu = {{DATA_W{1'b0}}, Y & w_bus};
            // Carry out of the adder lands in Zhigh[0]
            ALU_ADD: w_alu = {{(DATA_W-1){1'b0}}, {1'b0, Y} + {1'b0, w_bus}};
            default: w_alu = {{DATA_W{1'b0}}, w_bus};
        endcase
    end

    reg32 u_pc    (.i_clk(Clock), .i_clear(Clear), .i_load(PCin),  .i_d(w_pc_d),                  .o_q(PC));
    reg32 u_ir    (.i_clk(Clock), .i_clear(Clear), .i_load(IRin),  .i_d(w_bus),                   .o_q(IR));
    reg32 u_mar   (.i_clk(Clock), .i_clear(Clear), .i_load(MARin), .i_d(w_bus),                   .o_q(MAR));
    reg32 u_mdr   (.i_clk(Clock), .i_clear(Clear), .i_load(MDRin), .i_d(w_mdr_d),                 .o_q(MDR));
    reg32 u_y     (.i_clk(Clock), .i_clear(Clear), .i_load(Yin),   .i_d(w_bus),                   .o_q(Y));
    reg32 u_zhigh (.i_clk(Clock), .i_clear(Clear), .i_load(Zin),   .i_d(w_alu[2*DATA_W-1:DATA_W]), .o_q(Zhigh));
    reg32 u_zlow  (.i_clk(Clock), .i_clear(Clear), .i_load(Zin),   .i_d(w_alu[DATA_W-1:0]),        .o_q(Zlow));
    reg32 u_r1    (.i_clk(Clock), .i_clear(Clear), .i_load(R1in),  .i_d(w_bus),                   .o_q(R1));
    reg32 u_r2    (.i_clk(Clock), .i_clear(Clear), .i_load(R2in),  .i_d(w_bus),                   .o_q(R2));
    reg32 u_r3    (.i_clk(Clock), .i_clear(Clear), .i_load(R3in),  .i_d(w_bus),                   .o_q(R3));

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench for datapath (expected register values queued per cycle)
module tb_datapath;

    logic        Clock = 1'b0;
    logic        Clear, PCout, Zhighout, Zlowout, MDRout, R2out, R3out;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, AND;
    logic        R1in, R2in, R3in;
    logic [31:0] Mdatain;

    int total = 0;
    int bad   = 0;

    string       q_tag[$];
    int          q_id[$];
    logic [31:0] q_val[$];

    localparam int ID_PC = 0, ID_IR = 1, ID_MAR = 2, ID_MDR = 3, ID_Y = 4;
    localparam int ID_ZH = 5, ID_ZL = 6, ID_R1 = 7, ID_R2 = 8, ID_R3 = 9;

    datapath DUT (
        .Clock(Clock), .Clear(Clear), .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MDRout(MDRout), .R2out(R2out), .R3out(R3out), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .AND(AND),
        .R1in(R1in), .R2in(R2in), .R3in(R3in), .Mdatain(Mdatain)
    );

    always #5 Clock = ~Clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] peek(input int id);
        case (id)
            ID_PC:   return DUT.PC;
            ID_IR:   return DUT.IR;
            ID_MAR:  return DUT.MAR;
            ID_MDR:  return DUT.MDR;
            ID_Y:    return DUT.Y;
            ID_ZH:   return DUT.Zhigh;
            ID_ZL:   return DUT.Zlow;
            ID_R1:   return DUT.R1;
            ID_R2:   return DUT.R2;
            default: return DUT.R3;
        endcase
    endfunction

    task automatic expect_reg(input string tag, input int id, input logic [31:0] v);
        q_tag.push_back(tag);
        q_id.push_back(id);
        q_val.push_back(v);
    endtask

    task automatic idle();
        {Clear, PCout, Zhighout, Zlowout, MDRout, R2out, R3out} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read, AND, R1in, R2in, R3in} = '0;
    endtask

    // One clock edge, then drain the scoreboard against the registers and release all strobes
    task automatic tick();
        @(posedge Clock);
        #1;
        while (q_id.size() > 0)
            check_val(q_tag.pop_front(), peek(q_id.pop_front()), q_val.pop_front());
        idle();
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i < 10; i++)
            expect_reg($sformatf("%s_r%0d", tag, i), i, 32'h0);
    endtask

    function automatic logic [63:0] alu_nonand(input logic [31:0] y, input logic [31:0] b);
`ifdef DATAPATH_ADD_EN
        return {31'h0, {1'b0, y} + {1'b0, b}};
`else
        return {32'h0, b};
`endif
    endfunction

    logic [63:0] z_exp;

    initial begin
        idle();
        Mdatain = 32'h0;
        @(negedge Clock);

        Clear = 1'b1; expect_all_zero("reset"); tick();
        check_val("bus_idle", DUT.w_bus, 32'h0);

        Mdatain = 32'h12; Read = 1; MDRin = 1; expect_reg("mdr_12", ID_MDR, 32'h12); tick();
        MDRout = 1; R2in = 1; expect_reg("r2_load", ID_R2, 32'h12); tick();
        Mdatain = 32'h14; Read = 1; MDRin = 1; tick();
        MDRout = 1; R3in = 1; expect_reg("r3_load", ID_R3, 32'h14); tick();
        Mdatain = 32'h18; Read = 1; MDRin = 1; tick();
        MDRout = 1; R1in = 1; expect_reg("r1_load", ID_R1, 32'h18); tick();

        PCout = 1; MARin = 1; expect_reg("mar_pc", ID_MAR, 32'h0); tick();
        PCin = 1; IncPC = 1; expect_reg("pc_inc", ID_PC, 32'h1); tick();
        Mdatain = 32'h28918000; Read = 1; MDRin = 1; tick();
        MDRout = 1; IRin = 1; expect_reg("ir_load", ID_IR, 32'h28918000); tick();

        R2out = 1; Yin = 1; expect_reg("y_r2", ID_Y, 32'h12); tick();
        R3out = 1; AND = 1; Zin = 1;
        expect_reg("zlow_and", ID_ZL, 32'h10); expect_reg("zhigh_and", ID_ZH, 32'h0); tick();
        Zlowout = 1; R1in = 1; expect_reg("r1_and", ID_R1, 32'h10); tick();

        PCout = 1; MDRout = 1; Yin = 1; #1;
        check_val("bus_prio_pc", DUT.w_bus, 32'h1);
        expect_reg("y_prio", ID_Y, 32'h1); tick();
        R2out = 1; R3out = 1; Yin = 1; expect_reg("y_r2_over_r3", ID_Y, 32'h12); tick();
        MDRin = 1; Read = 0; R3out = 1; expect_reg("mdr_bus", ID_MDR, 32'h14); tick();

        z_exp = alu_nonand(32'h12, 32'h14);
        R3out = 1; Zin = 1;
        expect_reg("zlow_nonand", ID_ZL, z_exp[31:0]); expect_reg("zhigh_nonand", ID_ZH, z_exp[63:32]); tick();
        Zlowout = 1; Yin = 1; expect_reg("y_zlow", ID_Y, z_exp[31:0]); tick();

        R2out = 1; R2in = 1; expect_reg("r2_self", ID_R2, 32'h12); tick();
        IncPC = 1; expect_reg("pc_hold", ID_PC, 32'h1); tick();

        Clear = 1; Zin = 1; AND = 1; R2out = 1; expect_all_zero("midreset"); tick();

        Mdatain = 32'hFFFFFFFF; Read = 1; MDRin = 1; tick();
        MDRout = 1; PCin = 1; expect_reg("pc_bus", ID_PC, 32'hFFFFFFFF); tick();
        PCin = 1; IncPC = 1; expect_reg("pc_wrap", ID_PC, 32'h0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
